// File: rtl/sss_extractor.sv
// SSS extractor: after an SSB start trigger, counts FFT output symbols and forwards the
// 127 SSS subcarriers of SSB symbol SSS_SYM, together with the latched N_id_2.
module sss_extractor #(
  parameter int IN_DW     = 32,
  parameter int NFFT_LOG2 = 8,
  parameter int SSS_SYM   = 2
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             s_axis_in_tuser,
  input  logic             ssb_start_i,
  input  logic [1:0]       N_id_2_i,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  output logic             m_axis_out_tlast,
  output logic [1:0]       N_id_2_o,
  output logic             N_id_2_valid_o
);

  localparam int NFFT     = 1 << NFFT_LOG2;
  localparam int SSB_BIN0 = NFFT / 2 - 120;
  localparam logic [NFFT_LOG2-1:0] SSS_FIRST = NFFT_LOG2'(SSB_BIN0 + 56);
  localparam logic [NFFT_LOG2-1:0] SSS_LAST  = NFFT_LOG2'(SSB_BIN0 + 182);
  localparam int SYM_W = (SSS_SYM < 2) ? 1 : $clog2(SSS_SYM + 1);
  localparam logic [SYM_W-1:0] SSS_SYM_L = SYM_W'(SSS_SYM);

  typedef enum logic [1:0] {IDLE, WAIT_SSB, COUNT, EXTRACT} state_t;

  // With SSS_SYM = 0 the SSB's first symbol is already the SSS symbol.
  localparam state_t FIRST_STATE = (SSS_SYM == 0) ? EXTRACT : COUNT;

  state_t               state_q, state_d;
  logic [NFFT_LOG2-1:0] bin_q;
  logic [SYM_W-1:0]     sym_q, sym_d;
  logic [1:0]           nid_q;
  logic                 sof;
  logic                 emit, emit_first, emit_last;

  assign sof      = s_axis_in_tvalid & s_axis_in_tuser;
  assign N_id_2_o = nid_q;

  // Bin counter holds the index of the next non-tuser sample.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bin_q <= '0;
    end else if (s_axis_in_tvalid) begin
      bin_q <= s_axis_in_tuser ? NFFT_LOG2'(1) : bin_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      sym_q   <= '0;
      nid_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      if (ssb_start_i) nid_q <= N_id_2_i;
    end
  end

  // A new trigger overrides whatever is in flight; a same-cycle tuser is SSB symbol 0.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    if (ssb_start_i) begin
      if (sof) begin
        state_d = FIRST_STATE;
        sym_d   = '0;
      end else begin
        state_d = WAIT_SSB;
      end
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        WAIT_SSB: if (sof) begin
          state_d = FIRST_STATE;
          sym_d   = '0;
        end
        COUNT:    if (sof) begin
          sym_d = sym_q + 1'b1;
          if (sym_q + 1'b1 == SSS_SYM_L) state_d = EXTRACT;
        end
        EXTRACT:  if (sof || emit_last) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // A tuser sample is bin 0 and never inside the SSS window, so it is never emitted.
  always_comb begin
    emit       = (state_q == EXTRACT) && s_axis_in_tvalid && !s_axis_in_tuser &&
                 (bin_q >= SSS_FIRST) && (bin_q <= SSS_LAST);
    emit_first = emit && (bin_q == SSS_FIRST);
    emit_last  = emit && (bin_q == SSS_LAST);
  end

  // NOTE: the data register is a plain flop, so it is reset like the other outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      N_id_2_valid_o    <= 1'b0;
    end else begin
      if (emit) m_axis_out_tdata <= s_axis_in_tdata;
      m_axis_out_tvalid <= emit;
      m_axis_out_tlast  <= emit_last;
      N_id_2_valid_o    <= emit_first;
    end
  end

endmodule

// File: tb/tb_sss_extractor.sv
// Bench for sss_extractor: randomized FFT-like symbol streams checked every cycle
// against an event-level model, plus literal burst expectations per scenario.
module tb_sss_extractor;

  localparam int IN_DW     = 32;
  localparam int NFFT_LOG2 = 8;
  localparam int SSS_SYM   = 2;
  localparam int NFFT      = 1 << NFFT_LOG2;
  localparam int SSS_FIRST = NFFT / 2 - 120 + 56;
  localparam int SSS_LAST  = NFFT / 2 - 120 + 182;

  logic             clk_i = 1'b0;
  logic             reset_ni = 1'b0;
  logic [IN_DW-1:0] s_axis_in_tdata = '0;
  logic             s_axis_in_tvalid = 1'b0;
  logic             s_axis_in_tuser = 1'b0;
  logic             ssb_start_i = 1'b0;
  logic [1:0]       N_id_2_i = '0;
  logic [IN_DW-1:0] m_axis_out_tdata;
  logic             m_axis_out_tvalid;
  logic             m_axis_out_tlast;
  logic [1:0]       N_id_2_o;
  logic             N_id_2_valid_o;

  sss_extractor #(.IN_DW(IN_DW), .NFFT_LOG2(NFFT_LOG2), .SSS_SYM(SSS_SYM)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .s_axis_in_tuser   (s_axis_in_tuser),
    .ssb_start_i       (ssb_start_i),
    .N_id_2_i          (N_id_2_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .N_id_2_o          (N_id_2_o),
    .N_id_2_valid_o    (N_id_2_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Model: m_syms = -2 not armed, -1 armed waiting for symbol 0, >=0 symbols counted.
  int         m_next_bin;
  int         m_syms;
  bit         m_extract;
  logic [1:0] m_nid;
  bit         e_valid, e_last, e_nv;
  logic [31:0] e_data;

  // Observed-output log, used for the literal per-scenario expectations.
  int          tot_out = 0, tot_last = 0, tot_nv = 0;
  logic [31:0] out_log [int];
  logic [31:0] nv_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_next_bin = 0;
    m_syms     = -2;
    m_extract  = 1'b0;
    m_nid      = '0;
    e_valid    = 1'b0;
    e_last     = 1'b0;
    e_nv       = 1'b0;
    e_data     = '0;
  endfunction

  // Evaluates the sample just taken at the clock edge; e_* are the outputs it must cause.
  function automatic void model_step();
    bit v = s_axis_in_tvalid;
    bit u = s_axis_in_tuser;
    int idx = -1;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_nv    = 1'b0;
    if (v) begin
      idx        = u ? 0 : m_next_bin;
      m_next_bin = (idx + 1) % NFFT;
    end
    if (m_extract && v && !u && idx >= SSS_FIRST && idx <= SSS_LAST) begin
      e_valid = 1'b1;
      e_data  = s_axis_in_tdata;
      e_nv    = (idx == SSS_FIRST);
      e_last  = (idx == SSS_LAST);
      if (e_last) m_extract = 1'b0;
    end
    if (m_extract && v && u) m_extract = 1'b0;
    if (ssb_start_i) begin
      m_nid     = N_id_2_i;
      m_extract = 1'b0;
      m_syms    = -1;
    end
    if (v && u && m_syms >= -1) begin
      m_syms++;
      if (m_syms == SSS_SYM) begin
        m_extract = 1'b1;
        m_syms    = -2;
      end
    end
  endfunction

  task automatic compare();
    if (!check_en) return;
    check("tvalid", m_axis_out_tvalid, e_valid);
    check("tlast", m_axis_out_tlast, e_last);
    check("nid_valid", N_id_2_valid_o, e_nv);
    check("nid", N_id_2_o, m_nid);
    if (e_valid) check("tdata", m_axis_out_tdata, e_data);
    if (m_axis_out_tvalid) begin
      out_log[tot_out] = m_axis_out_tdata;
      tot_out++;
      if (m_axis_out_tlast) tot_last++;
      if (N_id_2_valid_o) begin
        tot_nv++;
        nv_data = m_axis_out_tdata;
      end
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare mid-cycle.
  task automatic cyc(input bit v, input bit u, input logic [31:0] d, input bit st,
                     input logic [1:0] nid);
    s_axis_in_tvalid = v;
    s_axis_in_tuser  = u;
    s_axis_in_tdata  = d;
    ssb_start_i      = st;
    N_id_2_i         = nid;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), $urandom, 1'b0, 2'($urandom));
  endtask

  task automatic start_pulse(input logic [1:0] nid);
    cyc(1'b0, 1'b0, $urandom, 1'b1, nid);
  endtask

  // One symbol of nbins samples tagged {tag, bin}; duty is the valid percentage.
  task automatic send_symbol(input int tag, input int nbins, input int duty,
                             input int start_bin, input logic [1:0] nid);
    for (int b = 0; b < nbins; b++) begin
      while (int'($urandom_range(99)) >= duty) idle(1);
      cyc(1'b1, b == 0, {16'(tag), 16'(b)}, b == start_bin,
          (b == start_bin) ? nid : 2'($urandom));
    end
  endtask

  initial begin
    int base;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tvalid", m_axis_out_tvalid, 1'b0);
    check("rst_tlast", m_axis_out_tlast, 1'b0);
    check("rst_tdata", m_axis_out_tdata, 32'h0);
    check("rst_nid", N_id_2_o, 2'd0);
    check("rst_nid_valid", N_id_2_valid_o, 1'b0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    check_en = 1'b1;
    idle(4);

    // 1: nominal, no gaps.
    base = tot_out;
    start_pulse(2'd1);
    for (int s = 0; s < 4; s++) send_symbol(s, NFFT, 100, -1, 2'd0);
    idle(4);
    check("t1_count", tot_out - base, 127);
    check("t1_first", out_log[base], 32'h0002_0040);
    check("t1_last", out_log[tot_out-1], 32'h0002_00BE);
    check("t1_tlast_cnt", tot_last, 1);
    check("t1_nv_cnt", tot_nv, 1);
    check("t1_nv_data", nv_data, 32'h0002_0040);
    check("t1_nid", N_id_2_o, 2'd1);

    // 2: ~50% valid duty.
    base = tot_out;
    start_pulse(2'd3);
    for (int s = 0; s < 4; s++) send_symbol(s, NFFT, 50, -1, 2'd0);
    idle(4);
    check("t2_count", tot_out - base, 127);
    check("t2_first", out_log[base], 32'h0002_0040);
    check("t2_last", out_log[tot_out-1], 32'h0002_00BE);
    check("t2_tlast_cnt", tot_last, 2);

    // 3: trigger coincident with symbol 0's tuser.
    base = tot_out;
    send_symbol(0, NFFT, 100, 0, 2'd2);
    for (int s = 1; s < 4; s++) send_symbol(s, NFFT, 100, -1, 2'd0);
    idle(4);
    check("t3_count", tot_out - base, 127);
    check("t3_first", out_log[base], 32'h0002_0040);
    check("t3_nid", N_id_2_o, 2'd2);

    // 4: retrigger during bin 101 of the SSS symbol; bins 64..101 still emitted.
    base = tot_out;
    start_pulse(2'd3);
    send_symbol(0, NFFT, 70, -1, 2'd0);
    send_symbol(1, NFFT, 70, -1, 2'd0);
    send_symbol(2, NFFT, 70, 101, 2'd0);
    for (int s = 3; s < 7; s++) send_symbol(s, NFFT, 70, -1, 2'd0);
    idle(4);
    check("t4_count", tot_out - base, 38 + 127);
    check("t4_cut", out_log[base+37], 32'h0002_0065);
    check("t4_restart", out_log[base+38], 32'h0005_0040);
    check("t4_tlast_cnt", tot_last, 4);
    check("t4_nid", N_id_2_o, 2'd0);

    // 5: SSS symbol truncated after bin 150.
    base = tot_out;
    start_pulse(2'd1);
    send_symbol(0, NFFT, 100, -1, 2'd0);
    send_symbol(1, NFFT, 100, -1, 2'd0);
    send_symbol(2, 151, 100, -1, 2'd0);
    for (int s = 3; s < 6; s++) send_symbol(s, NFFT, 100, -1, 2'd0);
    idle(4);
    check("t5_count", tot_out - base, 87);
    check("t5_last", out_log[tot_out-1], 32'h0002_0096);
    check("t5_tlast_cnt", tot_last, 4);

    // 6: asynchronous reset in the middle of extraction.
    start_pulse(2'd2);
    send_symbol(0, NFFT, 100, -1, 2'd0);
    send_symbol(1, NFFT, 100, -1, 2'd0);
    send_symbol(2, 100, 100, -1, 2'd0);
    check("t6_pre_valid", m_axis_out_tvalid, 1'b1);
    #1 reset_ni = 1'b0;
    check_en = 1'b0;
    #1;
    check("t6_async_tvalid", m_axis_out_tvalid, 1'b0);
    check("t6_async_tdata", m_axis_out_tdata, 32'h0);
    check("t6_async_tlast", m_axis_out_tlast, 1'b0);
    check("t6_async_nid", N_id_2_o, 2'd0);
    check("t6_async_nid_valid", N_id_2_valid_o, 1'b0);
    idle(3);
    model_reset();
    reset_ni = 1'b1;
    check_en = 1'b1;
    base = tot_out;
    for (int s = 3; s < 8; s++) send_symbol(s, NFFT, 100, -1, 2'd0);
    idle(4);
    check("t6_no_output", tot_out - base, 0);
    base = tot_out;
    start_pulse(2'd2);
    for (int s = 0; s < 4; s++) send_symbol(s, NFFT, 100, -1, 2'd0);
    idle(4);
    check("t6_count", tot_out - base, 127);
    check("t6_last", out_log[tot_out-1], 32'h0002_00BE);
    check("t6_nid", N_id_2_o, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
